sim_writer_nch: RTL and testbench
=================================

// Module: sim_writer_nch
// PURPOSE
//  Parametrised N-channel simulated write engine used by testbenches. Stands in for
//  real write paths (HSI, SPI, ...) behind the bench controller. Each channel accepts
//  start pulses and completes them after a programmable latency. Further starts queue
//  up to a fixed depth, and each completed job produces a one-cycle done strobe.
// PARAMETERS
//  NUM_CH       2   number of independent channels (1..16)
//  CNT_W        32  width of each channel's latency counter
//  DEF_LATENCY  50  latency used when the channel's latency input is 0
//  QUEUE_DEPTH  4   pending starts held per channel while it is busy (1..15)
// PORTS
//  clk       in   1             single clock; all logic on its rising edge
//  resetn    in   1             asynchronous, active-low reset
//  start     in   NUM_CH        per-channel start request, 1-cycle pulse
//  flush     in   NUM_CH        per-channel abort; clears the active job and the queue
//  latency   in   NUM_CH*CNT_W  per-channel latency; channel i uses [i*CNT_W +: CNT_W]
//  complete  out  NUM_CH        level: channel idle (timer==0 and pending==0)
//  done      out  NUM_CH        1-cycle pulse: one job finished
//  pending   out  NUM_CH*4      per-channel queued-start count (zero-extended)
//  overflow  out  NUM_CH        sticky: a start was dropped because the queue was full
//  clr_ovf   in   NUM_CH        clears overflow[i]
// BEHAVIOUR
//  Reset (asynchronous, resetn=0): timer=0, pending=0, done=0, overflow=0.
//   This gives complete=all ones.
//  Effective latency: L = (latency_i==0) ? DEF_LATENCY : latency_i. L is always >= 1.
//  Per-channel states:
//   IDLE (timer==0, pending==0) and BUSY (timer!=0).
//  IDLE + start: timer<=L. complete drops on the following cycle.
//   complete rises again exactly L edges after the start edge, as the timer reaches 0.
//  BUSY, every edge: timer decrements by 1.
//  BUSY + start:
//   pending<QUEUE_DEPTH -> pending+1.
//   pending==QUEUE_DEPTH -> start dropped, overflow<=1.
//  Terminal edge (timer==1):
//   done<=1 for exactly one cycle.
//   If pending>0: timer<=L, sampled from latency at this edge; pending-1; complete stays 0.
//   If pending==0: timer<=0 and the channel goes IDLE.
//  Terminal edge + start: the reload consumes one queued job and the start queues one.
//   Net pending is unchanged; no overflow, even at QUEUE_DEPTH.
//  Queued jobs take latency from the reload edge, not from their own start edge.
//  flush: highest priority. timer<=0, pending<=0, no done pulse.
//   A start in the same cycle as flush is ignored.
//  clr_ovf and a new overflow in the same cycle: set wins (overflow stays 1).
//  No wrap-around: the timer never decrements below 0, and pending saturates at QUEUE_DEPTH.
//  Channels are fully independent; simultaneous starts on all channels are legal.
//  Reset mid-job: everything returns to reset values immediately and no done pulse is issued.
// STRUCTURE
//  Shared package sim_writer_pkg:
//   DEF_LATENCY default, PEND_W=4, and the channel state encoding (IDLE/BUSY).
//  One sub-module, sim_writer_chan: timer, pending counter, done and overflow for one channel.
//  The top level holds a generate loop of NUM_CH instances plus bus slicing only.
// TESTING
//  1 Reset, latency=0, start ch0 at edge t ->
//    complete[0]=0 from t+1 to t+49, =1 at t+50; done[0] high in cycle t+50 only.
//  2 latency_1=3, start ch1 three times on consecutive cycles ->
//    pending peaks at 2; done pulses at t+3, t+6, t+9; complete[1]=1 at t+9.
//  3 QUEUE_DEPTH=4, latency=10, 6 starts while busy ->
//    pending=4, overflow=1, exactly 5 done pulses; clr_ovf clears overflow.
//  4 start on the timer==1 edge with pending=4 ->
//    pending stays 4, overflow stays 0, done pulses once.
//  5 flush ch0 mid-job with pending=2, plus start in the same cycle ->
//    complete=1 next cycle, pending=0, no done.
//    Ch1 is unaffected throughout.
//  6 Drop resetn asynchronously mid-job (between edges) ->
//    outputs go to reset values without a clock; no done after resetn rises.

Source files
------------

// File: rtl/sim_writer_pkg.sv
// sim_writer_pkg: shared constants for the simulated N-channel write engine.
// Holds the default latency, pending-count width and channel state codes.
package sim_writer_pkg;

    localparam int DEF_LATENCY_DFLT = 50;
    localparam int PEND_W           = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/sim_writer_if.sv
// sim_writer_if: per-channel control/status bus of the simulated write engine.
// master drives start/flush/latency/clr_ovf; slave returns complete/done/pending/overflow.
interface sim_writer_if
    import sim_writer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);

    logic [NUM_CH-1:0]        start;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH-1:0]        clr_ovf;
    logic [NUM_CH*CNT_W-1:0]  latency;
    logic [NUM_CH-1:0]        complete;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        overflow;
    logic [NUM_CH*PEND_W-1:0] pending;

    modport master (
        output start, flush, clr_ovf, latency,
        input  complete, done, overflow, pending
    );

    modport slave (
        input  start, flush, clr_ovf, latency,
        output complete, done, overflow, pending
    );

endinterface

// File: rtl/sim_writer_chan.sv
// sim_writer_chan: one channel - latency timer, pending queue count, done strobe, sticky overflow.
// Ports: clk, resetn, start, flush, clr_ovf, latency in; complete, done, pending, overflow out.
module sim_writer_chan
    import sim_writer_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEF_LATENCY = DEF_LATENCY_DFLT,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              flush,
    input  logic              clr_ovf,
    input  logic [CNT_W-1:0]  latency,
    output logic              complete,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  DEF_L = CNT_W'(DEF_LATENCY);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] QD    = PEND_W'(QUEUE_DEPTH);

    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  eff_lat;
    logic [PEND_W-1:0] pend;
    logic              state;
    logic              terminal;
    logic              ovf_set;

    always_comb begin
        eff_lat  = (latency == '0) ? DEF_L : latency;
        state    = (timer != '0) ? ST_BUSY : ST_IDLE;
        terminal = (timer == ONE);
        // A start on the terminal edge is absorbed by the reload, so it
        // never overflows even with a full queue.
        ovf_set  = !flush && start && (state == ST_BUSY)
                   && !terminal && (pend == QD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
            pend  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                timer <= '0;
                pend  <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start)
                            timer <= eff_lat;
                    end
                    ST_BUSY: begin
                        if (terminal) begin
                            done <= 1'b1;
                            if (start) begin
                                timer <= eff_lat;
                            end else if (pend != '0) begin
                                timer <= eff_lat;
                                pend  <= pend - 1'b1;
                            end else begin
                                timer <= '0;
                            end
                        end else begin
                            timer <= timer - ONE;
                            if (start && pend != QD)
                                pend <= pend + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    assign complete = (state == ST_IDLE) && (pend == '0);
    assign pending  = pend;

endmodule

// File: rtl/sim_writer_nch.sv
// sim_writer_nch: NUM_CH independent simulated write channels behind one bus.
// Ports: clk, resetn (async, active-low), bus (sim_writer_if.slave, channel i in slice i).
module sim_writer_nch
    import sim_writer_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int DEF_LATENCY = DEF_LATENCY_DFLT,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    sim_writer_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sim_writer_chan #(
            .CNT_W       (CNT_W),
            .DEF_LATENCY (DEF_LATENCY),
            .QUEUE_DEPTH (QUEUE_DEPTH)
        ) u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .start    (bus.start[i]),
            .flush    (bus.flush[i]),
            .clr_ovf  (bus.clr_ovf[i]),
            .latency  (bus.latency[i*CNT_W +: CNT_W]),
            .complete (bus.complete[i]),
            .done     (bus.done[i]),
            .pending  (bus.pending[i*PEND_W +: PEND_W]),
            .overflow (bus.overflow[i])
        );
    end

endmodule

// File: tb/tb_sim_writer_nch.sv
// tb_sim_writer_nch: directed, table-driven bench for sim_writer_nch.
// Drives the interface as master; outputs sampled 1ns after each rising edge.
module tb_sim_writer_nch;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    int   dc0;
    int   dc1;

    sim_writer_if #(.NUM_CH(2), .CNT_W(32)) bus ();

    sim_writer_nch #(
        .NUM_CH      (2),
        .CNT_W       (32),
        .DEF_LATENCY (50),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [3:0] pend;
        logic       dn;
        logic       cmp;
    } vec_t;

    vec_t tv[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done[0] === 1'b1) dc0++;
        if (bus.done[1] === 1'b1) dc1++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic bad_c;
        logic bad_d;

        tv[0]  = '{1'b1, 4'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 4'd1, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 4'd2, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 4'd1, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 4'd1, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 4'd1, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 4'd0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 4'd0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 4'd0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 4'd0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 4'd0, 1'b0, 1'b1};

        n_checks    = 0;
        n_fail      = 0;
        dc0         = 0;
        dc1         = 0;
        resetn      = 1'b0;
        bus.start   = '0;
        bus.flush   = '0;
        bus.clr_ovf = '0;
        bus.latency = '0;

        // reset state
        ticks(2);
        check("rst_complete", 32'(bus.complete), 32'h3);
        check("rst_done",     32'(bus.done),     32'h0);
        check("rst_pending",  32'(bus.pending),  32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        resetn = 1'b1;
        tick();

        // 1: default latency 50 on ch0
        dc0 = 0;
        bus.start[0] = 1'b1;
        tick();
        bus.start[0] = 1'b0;
        bad_c = bus.complete[0];
        bad_d = bus.done[0];
        for (int k = 0; k < 49; k++) begin
            tick();
            if (bus.complete[0] !== 1'b0) bad_c = 1'b1;
            if (bus.done[0] !== 1'b0) bad_d = 1'b1;
        end
        check("t1_busy_complete", 32'(bad_c), 32'h0);
        check("t1_early_done",    32'(bad_d), 32'h0);
        tick();
        check("t1_complete_t50", 32'(bus.complete[0]), 32'h1);
        check("t1_done_t50",     32'(bus.done[0]),     32'h1);
        tick();
        check("t1_done_t51", 32'(bus.done[0]), 32'h0);
        check("t1_dc0",      32'(dc0),         32'd1);

        // 2: ch1 latency 3, three back-to-back starts (table)
        bus.latency[63:32] = 32'd3;
        for (int i = 0; i < 11; i++) begin
            bus.start[1] = tv[i].st;
            tick();
            check($sformatf("t2_pend[%0d]", i),
                  32'(bus.pending[7:4]), 32'(tv[i].pend));
            check($sformatf("t2_done[%0d]", i),
                  32'(bus.done[1]), 32'(tv[i].dn));
            check($sformatf("t2_cmpl[%0d]", i),
                  32'(bus.complete[1]), 32'(tv[i].cmp));
        end
        bus.start[1] = 1'b0;

        // 3: queue full, overflow, set beats clear
        bus.latency[31:0] = 32'd10;
        dc0 = 0;
        bus.start[0] = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.clr_ovf[0] = (k == 5);
            tick();
        end
        bus.start[0]   = 1'b0;
        bus.clr_ovf[0] = 1'b0;
        check("t3_pending",  32'(bus.pending[3:0]), 32'd4);
        check("t3_ovf_set",  32'(bus.overflow[0]),  32'h1);
        bus.clr_ovf[0] = 1'b1;
        tick();
        bus.clr_ovf[0] = 1'b0;
        check("t3_ovf_clr", 32'(bus.overflow[0]), 32'h0);
        ticks(70);
        check("t3_dones",    32'(dc0),              32'd5);
        check("t3_complete", 32'(bus.complete[0]),  32'h1);

        // 4: start on terminal edge with a full queue
        bus.latency[31:0] = 32'd6;
        bus.start[0] = 1'b1;
        ticks(5);
        bus.start[0] = 1'b0;
        tick();
        check("t4_pend_pre", 32'(bus.pending[3:0]), 32'd4);
        dc0 = 0;
        bus.start[0] = 1'b1;
        tick();
        bus.start[0] = 1'b0;
        check("t4_pend",  32'(bus.pending[3:0]), 32'd4);
        check("t4_ovf",   32'(bus.overflow[0]),  32'h0);
        check("t4_done",  32'(bus.done[0]),      32'h1);
        check("t4_dc0",   32'(dc0),              32'd1);
        ticks(40);
        check("t4_drain", 32'(bus.complete[0]),  32'h1);

        // 5: flush ch0 with start, ch1 unaffected
        bus.latency[31:0]  = 32'd10;
        bus.latency[63:32] = 32'd20;
        dc0 = 0;
        dc1 = 0;
        bus.start = 2'b11;
        tick();
        bus.start = 2'b01;
        ticks(2);
        check("t5_pend_pre", 32'(bus.pending[3:0]), 32'd2);
        bus.start    = 2'b01;
        bus.flush[0] = 1'b1;
        tick();
        bus.start    = 2'b00;
        bus.flush[0] = 1'b0;
        check("t5_complete0", 32'(bus.complete[0]), 32'h1);
        check("t5_pending0",  32'(bus.pending[3:0]), 32'd0);
        check("t5_done0",     32'(bus.done[0]),      32'h0);
        check("t5_complete1", 32'(bus.complete[1]), 32'h0);
        ticks(16);
        check("t5_ch1_t19", 32'({bus.complete[1], bus.done[1]}), 32'h0);
        tick();
        check("t5_ch1_t20", 32'({bus.complete[1], bus.done[1]}), 32'h3);
        ticks(5);
        check("t5_dc0", 32'(dc0), 32'd0);
        check("t5_dc1", 32'(dc1), 32'd1);

        // 6: asynchronous reset mid-job
        bus.latency[31:0]  = 32'd0;
        bus.latency[63:32] = 32'd10;
        bus.start = 2'b11;
        tick();
        bus.start = 2'b10;
        ticks(5);
        bus.start = 2'b00;
        check("t6_ovf_pre", 32'(bus.overflow), 32'h2);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_complete", 32'(bus.complete), 32'h3);
        check("t6_pending",  32'(bus.pending),  32'h0);
        check("t6_overflow", 32'(bus.overflow), 32'h0);
        check("t6_done",     32'(bus.done),     32'h0);
        @(negedge clk);
        resetn = 1'b1;
        dc0 = 0;
        dc1 = 0;
        ticks(60);
        check("t6_no_done", 32'(dc0 + dc1), 32'd0);
        check("t6_idle",    32'(bus.complete), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
